// File: rtl/joybus_rx_frame_if.sv
// Control and result bundle between a Joybus RX frame decoder and its consumer.
// The master side arms reception. The slave side is the decoder that reports bits and frame status.
interface joybus_rx_frame_if #(
    parameter int unsigned MAX_BITS = 64,
    parameter int unsigned IDX_W    = $clog2(MAX_BITS + 1)
);
    logic                rx_start;
    logic [IDX_W-1:0]    rx_len;
    logic [MAX_BITS-1:0] rx_data;
    logic [IDX_W-1:0]    rx_bit_cnt;
    logic                bit_valid;
    logic                bit_val;
    logic [IDX_W-1:0]    bit_idx;
    logic                tap_hit;
    logic                rx_done;
    logic [1:0]          rx_err;
    logic                busy;

    modport master (
        output rx_start, rx_len,
        input  rx_data, rx_bit_cnt, bit_valid, bit_val, bit_idx, tap_hit, rx_done, rx_err, busy
    );

    modport slave (
        input  rx_start, rx_len,
        output rx_data, rx_bit_cnt, bit_valid, bit_val, bit_idx, tap_hit, rx_done, rx_err, busy
    );
endinterface

// File: rtl/joybus_rx_frame.sv
// Joybus receive decoder: oversamples the line and votes each bit by its low and high durations.
// It captures a variable-length frame and streams every decoded bit.
module joybus_rx_frame #(
    parameter int unsigned MAX_BITS    = 64,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned STOP_CYC    = 100,
    parameter int unsigned TAP_BIT     = 32,
    parameter int unsigned IDX_W       = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jb_rx,
    joybus_rx_frame_if.slave bus
);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STOP_M1  = CNT_W'(STOP_CYC - 1);
    localparam bit               TAP_EN   = (TAP_BIT != 0);
    localparam logic [IDX_W-1:0] TAP_IDX  = TAP_EN ? IDX_W'(TAP_BIT - 1) : '0;
    localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_BITS);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, CNT_LOW, CNT_HIGH, DECIDE, STOP, FINISH} state_t;

    state_t              state, state_d;
    logic                sync1, line;
    logic [IDX_W-1:0]    len_q, len_d;
    logic                bad_q, bad_d;
    logic [1:0]          err_q, err_d;
    logic [CNT_W-1:0]    ph_cnt, ph_d, low_len, low_d, high_len, high_d;
    logic                dec_bit;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d, bidx_q, bidx_d;
    logic                bv_q, bv_d, bval_q, bval_d, tap_q, tap_d, done_q, done_d, busy_q, busy_d;
    logic [1:0]          rerr_q, rerr_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            line     <= 1'b1;
            state    <= IDLE;
            len_q    <= '0;
            bad_q    <= 1'b0;
            err_q    <= '0;
            ph_cnt   <= '0;
            low_len  <= '0;
            high_len <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            bv_q     <= 1'b0;
            bval_q   <= 1'b0;
            tap_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rerr_q   <= '0;
        end else begin
            sync1    <= jb_rx;
            line     <= sync1;
            state    <= state_d;
            len_q    <= len_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            ph_cnt   <= ph_d;
            low_len  <= low_d;
            high_len <= high_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            bv_q     <= bv_d;
            bval_q   <= bval_d;
            tap_q    <= tap_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rerr_q   <= rerr_d;
        end
    end

    // Next state; bit results are registered on the edge entering DECIDE, so they are visible during DECIDE
    always_comb begin
        state_d = state;
        len_d   = len_q;
        bad_d   = bad_q;
        err_d   = err_q;
        ph_d    = ph_cnt;
        low_d   = low_len;
        high_d  = high_len;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
        dec_bit = 1'b0;
        bidx_d  = '0;
        bv_d    = 1'b0;
        bval_d  = 1'b0;
        tap_d   = 1'b0;
        done_d  = 1'b0;

        if (bus.rx_start) begin
            len_d   = bus.rx_len;
            bad_d   = (bus.rx_len == '0) || (bus.rx_len > LEN_MAX);
            err_d   = '0;
            ph_d    = '0;
            low_d   = '0;
            high_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
            rerr_d  = '0;
            state_d = WAIT_LOW;
        end else begin
            unique case (state)
                IDLE: state_d = IDLE;
                WAIT_LOW: begin
                    if (bad_q) begin
                        err_d   = 2'd3;
                        state_d = FINISH;
                    end else if (!line) begin
                        low_d   = CNT_W'(1);
                        state_d = CNT_LOW;
                    end else if (ph_cnt >= TMO_M1) begin
                        ph_d    = TMO;
                        err_d   = 2'd1;
                        state_d = FINISH;
                    end else begin
                        ph_d = ph_cnt + CNT_W'(1);
                    end
                end
                CNT_LOW: begin
                    if (line) begin
                        high_d  = CNT_W'(1);
                        state_d = CNT_HIGH;
                    end else if (low_len >= TMO_M1) begin
                        low_d   = TMO;
                        err_d   = 2'd2;
                        state_d = FINISH;
                    end else begin
                        low_d = low_len + CNT_W'(1);
                    end
                end
                CNT_HIGH: begin
                    if (!line) begin
                        dec_bit = (high_len > low_len);
                        data_d  = (data_q << 1) | MAX_BITS'(dec_bit);
                        cnt_d   = cnt_q + IDX_W'(1);
                        bv_d    = 1'b1;
                        bval_d  = dec_bit;
                        bidx_d  = cnt_q;
                        tap_d   = TAP_EN && (cnt_q == TAP_IDX);
                        state_d = DECIDE;
                    end else if (high_len >= TMO_M1) begin
                        high_d  = TMO;
                        err_d   = 2'd2;
                        state_d = FINISH;
                    end else begin
                        high_d = high_len + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    // Edge cycle plus this cycle already belong to the next low phase
                    low_d   = CNT_W'(2);
                    high_d  = '0;
                    ph_d    = '0;
                    state_d = (cnt_q == len_q) ? STOP : CNT_LOW;
                end
                STOP: begin
                    if (line || (ph_cnt >= STOP_M1)) begin
                        err_d   = 2'd0;
                        state_d = FINISH;
                    end else begin
                        ph_d = ph_cnt + CNT_W'(1);
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    rerr_d  = err_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_bit_cnt = cnt_q;
    assign bus.bit_valid  = bv_q;
    assign bus.bit_val    = bval_q;
    assign bus.bit_idx    = bidx_q;
    assign bus.tap_hit    = tap_q;
    assign bus.rx_done    = done_q;
    assign bus.rx_err     = rerr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_joybus_rx_frame.sv
// Directed bench for joybus_rx_frame: a table of whole frames plus hand sequences for skew, restart and reset.
module tb_joybus_rx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jb_rx = 1'b1;

    joybus_rx_frame_if #(.MAX_BITS(64)) bus ();

    joybus_rx_frame #(
        .MAX_BITS(64), .CNT_W(8), .TIMEOUT_CYC(200), .STOP_CYC(100), .TAP_BIT(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .jb_rx(jb_rx),
        .bus  (bus)
    );

    always #20 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Monitor state, sampled on the falling edge
    logic sv_q[$];
    int   si_q[$];
    int   tap_cnt = 0;
    int   tap_idx = -1;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic [1:0] done_err = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bit_valid) begin
            sv_q.push_back(bus.bit_val);
            si_q.push_back(int'(bus.bit_idx));
        end
        if (bus.tap_hit) begin
            tap_cnt = tap_cnt + 1;
            tap_idx = bus.bit_valid ? int'(bus.bit_idx) : -2;
        end
        if (bus.rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = bus.rx_err;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic pulse_start(input logic [6:0] len);
        @(negedge clk);
        sv_q.delete();
        si_q.delete();
        tap_cnt = 0;
        tap_idx = -1;
        done_cnt = 0;
        bus.rx_start = 1'b1;
        bus.rx_len = len;
        @(negedge clk);
        bus.rx_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_raw(input int lo, input int hi);
        jb_rx = 1'b0;
        repeat (lo) @(negedge clk);
        jb_rx = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_raw(25, 75);
        else   send_raw(75, 25);
    endtask

    task automatic send_stop();
        jb_rx = 1'b0;
        repeat (25) @(negedge clk);
        jb_rx = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    endtask

    typedef struct {
        logic [6:0]  len;
        logic [63:0] pat;
        int          nsend;
        bit          stuck;
        logic [1:0]  exp_err;
        logic [6:0]  exp_cnt;
        logic [63:0] exp_data;
        int          exp_tap;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_start = 1'b0;
        bus.rx_len = '0;

        vecs[0] = '{7'd8,  64'hA5,                  8,  1'b0, 2'd0, 7'd8,  64'hA5,                  0, 0};
        vecs[1] = '{7'd16, 64'h1234,                16, 1'b0, 2'd0, 7'd16, 64'h1234,                0, 0};
        vecs[2] = '{7'd1,  64'h1,                   1,  1'b0, 2'd0, 7'd1,  64'h1,                   0, 0};
        vecs[3] = '{7'd64, 64'hDEAD_BEEF_0123_4567, 64, 1'b0, 2'd0, 7'd64, 64'hDEAD_BEEF_0123_4567, 1, 0};
        vecs[4] = '{7'd64, 64'h0,                   0,  1'b0, 2'd1, 7'd0,  64'h0,                   0, 201};
        vecs[5] = '{7'd0,  64'h0,                   0,  1'b0, 2'd3, 7'd0,  64'h0,                   0, 2};
        vecs[6] = '{7'd65, 64'h0,                   0,  1'b0, 2'd3, 7'd0,  64'h0,                   0, 2};
        vecs[7] = '{7'd64, 64'hA5_5AC3_3CF0,        40, 1'b1, 2'd2, 7'd40, 64'h0000_00A5_5AC3_3CF0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_data", bus.rx_data, 64'h0);
        check("rst_bit_cnt", 64'(bus.rx_bit_cnt), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done_err", 64'({bus.rx_done, bus.rx_err, bus.bit_valid, bus.tap_hit}), 64'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table of whole frames
        for (int v = 0; v < 8; v++) begin
            pulse_start(vecs[v].len);
            for (int i = 0; i < vecs[v].nsend; i++) send_bit(vecs[v].pat[vecs[v].nsend - 1 - i]);
            if (vecs[v].stuck) jb_rx = 1'b0;
            else if (vecs[v].nsend > 0) send_stop();
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_err", v), 64'(done_err), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_bit_cnt", v), 64'(bus.rx_bit_cnt), 64'(vecs[v].exp_cnt));
            check($sformatf("v%0d_rx_data", v), bus.rx_data, vecs[v].exp_data);
            check($sformatf("v%0d_nstrobe", v), 64'(sv_q.size()), 64'(vecs[v].exp_cnt));
            for (int i = 0; i < sv_q.size() && i < int'(vecs[v].exp_cnt); i++) begin
                check($sformatf("v%0d_bit%0d_val", v, i), 64'(sv_q[i]), 64'(vecs[v].pat[vecs[v].nsend - 1 - i]));
                check($sformatf("v%0d_bit%0d_idx", v, i), 64'(si_q[i]), 64'(i));
            end
            check($sformatf("v%0d_tap_cnt", v), 64'(tap_cnt), 64'(vecs[v].exp_tap));
            if (vecs[v].exp_tap != 0) check($sformatf("v%0d_tap_idx", v), 64'(tap_idx), 64'd31);
            if (vecs[v].exp_lat != 0)
                check($sformatf("v%0d_latency", v), 64'(done_cyc - start_cyc), 64'(vecs[v].exp_lat));
            jb_rx = 1'b1;
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_err_held", v), 64'(bus.rx_err), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_idle", v), 64'({bus.busy, bus.rx_done}), 64'h0);
            check($sformatf("v%0d_done_once", v), 64'(done_cnt), 64'd1);
        end

        // Skewed timing with a tie
        pulse_start(7'd3);
        send_raw(55, 45);
        send_raw(45, 55);
        send_raw(50, 50);
        send_stop();
        wait_done("skew");
        check("skew_nstrobe", 64'(sv_q.size()), 64'd3);
        if (sv_q.size() == 3) check("skew_vals", 64'({sv_q[0], sv_q[1], sv_q[2]}), 64'b010);
        check("skew_rx_data", bus.rx_data, 64'h2);
        check("skew_err", 64'(done_err), 64'd0);
        repeat (5) @(negedge clk);

        // Restart mid-frame after 10 bits
        pulse_start(7'd16);
        for (int i = 9; i >= 0; i--) begin
            logic [9:0] p;
            p = 10'b10_1100_1110;
            send_bit(p[i]);
        end
        jb_rx = 1'b0;
        repeat (10) @(negedge clk);
        jb_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("restart_pre_cnt", 64'(bus.rx_bit_cnt), 64'd10);
        check("restart_pre_data", bus.rx_data, 64'h2CE);
        check("restart_pre_nodone", 64'(done_cnt), 64'd0);
        pulse_start(7'd8);
        check("restart_cnt_clr", 64'(bus.rx_bit_cnt), 64'd0);
        check("restart_data_clr", bus.rx_data, 64'h0);
        check("restart_busy", 64'(bus.busy), 64'd1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] p;
            p = 8'h3C;
            send_bit(p[i]);
        end
        send_stop();
        wait_done("restart");
        check("restart_err", 64'(done_err), 64'd0);
        check("restart_data", bus.rx_data, 64'h3C);
        check("restart_nstrobe", 64'(sv_q.size()), 64'd8);
        repeat (5) @(negedge clk);

        // Synchronous reset mid-frame
        pulse_start(7'd8);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        jb_rx = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_pre_data", bus.rx_data, 64'h7);
        check("midrst_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rx_data", bus.rx_data, 64'h0);
        check("midrst_bit_cnt", 64'(bus.rx_bit_cnt), 64'h0);
        check("midrst_busy", 64'(bus.busy), 64'h0);
        check("midrst_strobes", 64'({bus.rx_done, bus.rx_err, bus.bit_valid, bus.bit_val, bus.tap_hit}), 64'h0);
        check("midrst_bit_idx", 64'(bus.bit_idx), 64'h0);
        jb_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
